// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue
//   Issue stage in front of the 16-bit shift unit. Shift commands {a, s, w, l}
//   are queued in a DEPTH-entry FIFO. The head entry is presented on sh_*
//   straight from storage. The unit's combinational result sh_b is captured
//   into a result register with a valid/ready handshake towards the consumer.
//
//   Build option: SHQ_BYPASS_EN
//     When defined, an empty queue forwards an offered command directly onto
//     sh_* and captures its result in the same cycle. The FIFO is skipped and
//     latency drops by one.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   command handshake (in_ready = queue not full)
//   in_a/in_s/in_w/in_l command fields
//   sh_a/sh_s/sh_w/sh_l head command towards the shift unit (zero when empty)
//   sh_b                combinational result from the shift unit
//   out_valid/out_ready result handshake
//   out_data            registered result
//   level               number of queued entries (0..DEPTH)

module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_a,
  input  logic [3:0]    in_s,
  input  logic          in_w,
  input  logic          in_l,
  output logic [15:0]   sh_a,
  output logic [3:0]    sh_s,
  output logic          sh_w,
  output logic          sh_l,
  input  logic [15:0]   sh_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [AW:0]   level
);

  localparam int          CW   = 22;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;

  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;
  logic          cap;
  logic [CW-1:0] in_cmd;
  logic [CW-1:0] sh_cmd;

  assign in_cmd   = {in_a, in_s, in_w, in_l};
  assign empty    = (level_q == '0);
  assign in_ready = (level_q != FULL);

`ifdef SHQ_BYPASS_EN
  assign byp = empty && in_valid && (!out_valid_q || out_ready);
`else
  assign byp = 1'b0;
`endif

  // A bypassed command goes straight to the result register, never into storage.
  assign push = in_valid && in_ready && !byp;
  assign pop  = !empty && (!out_valid_q || out_ready);
  assign cap  = pop || byp;

  always_comb begin
    sh_cmd = '0;
    if (!empty) begin
      sh_cmd = mem_q[rd_ptr_q];
    end
`ifdef SHQ_BYPASS_EN
    else if (byp) begin
      sh_cmd = in_cmd;
    end
`endif
  end

  assign sh_a = sh_cmd[21:6];
  assign sh_s = sh_cmd[5:2];
  assign sh_w = sh_cmd[1];
  assign sh_l = sh_cmd[0];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_cmd;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // A result held while the consumer stalls is never overwritten.
    if (cap) begin
      out_data_d  = sh_b;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule
